ram_be_pipe: RTL

//   Single-port synchronous RAM, successor to the basic load/addr/d/q RAM.

---
 rtl/ram_be_pipe_pkg.sv | 24 ++
 rtl/ram_rd_pipe.sv | 60 ++++++
 rtl/ram_be_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ram_be_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ram_be_pipe_pkg
// Shared definitions for the byte-enabled pipelined RAM (ram_be_pipe) and its
// read pipeline (ram_rd_pipe): clear-FSM state encoding, byte-lane geometry
// and the legal read latency range.
// ---------------------------------------------------------------------------
package ram_be_pipe_pkg;

   // Clear sweep runs first after reset, then the RAM serves the datapath.
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } ram_state_t;

   localparam int BYTE_W           = 8;
   localparam int MIN_READ_LATENCY = 1;
   localparam int MAX_READ_LATENCY = 2;

   // Number of byte lanes in a data word.
   function automatic int lanes(input int width);
      return width / BYTE_W;
   endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// ---------------------------------------------------------------------------
// ram_rd_pipe
// Delays the first-stage read result {valid, data} by STAGES extra cycles.
// There is no stall: every valid that enters leaves STAGES cycles later.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset; empties the pipe
//   in_valid  in   valid of the first-stage read result
//   in_data   in   WIDTH  data of the first-stage read result
//   out_valid out  delayed valid
//   out_data  out  WIDTH  delayed data
// ---------------------------------------------------------------------------
module ram_rd_pipe
   import ram_be_pipe_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   generate
      if (STAGES == 0) begin : g_pass
         // Latency 1: the first stage in the top already is the output register.
         logic pipe_unused_s;
         assign pipe_unused_s = clk ^ reset;
         assign out_valid     = in_valid;
         assign out_data      = in_data;
      end else begin : g_pipe
         logic [STAGES-1:0] v_r;
         logic [WIDTH-1:0]  d_r [0:STAGES-1];

         // Shift valid and data together; reset zeroes data too so q reads 0 out of reset.
         always_ff @(posedge clk) begin
            if (reset) begin
               v_r <= {STAGES{1'b0}};
               for (int i = 0; i < STAGES; i++) begin
                  d_r[i] <= {WIDTH{1'b0}};
               end
            end else begin
               v_r[0] <= in_valid;
               d_r[0] <= in_data;
               for (int i = 1; i < STAGES; i++) begin
                  v_r[i] <= v_r[i-1];
                  d_r[i] <= d_r[i-1];
               end
            end
         end

         assign out_valid = v_r[STAGES-1];
         assign out_data  = d_r[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/ram_be_pipe.sv
// ---------------------------------------------------------------------------
// ram_be_pipe
// Single-port synchronous RAM with per-byte write enables, a read strobe with
// a 1- or 2-cycle read pipeline, selectable read-during-write behaviour and an
// automatic post-reset clear sweep.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset (memory contents untouched)
//   load     in   write strobe
//   be       in   WIDTH/8  byte enables, be[i] gates d[8i+7:8i]
//   rd_en    in   read strobe
//   addr     in   ADDR_WIDTH  word address shared by read and write
//   d        in   WIDTH  write data
//   q        out  WIDTH  read data, holds its value while q_valid=0
//   q_valid  out  q carries a read issued READ_LATENCY cycles earlier
//   busy     out  clear sweep running; load and rd_en are dropped
// ---------------------------------------------------------------------------
module ram_be_pipe
   import ram_be_pipe_pkg::*;
#(
   parameter int              WIDTH          = 16,
   parameter int              ADDR_WIDTH     = 12,
   parameter int              DEPTH          = 4096,
   parameter int              READ_LATENCY   = 1,
   parameter int              WRITE_FIRST    = 0,
   parameter int              CLEAR_ON_RESET = 1,
   parameter logic [WIDTH-1:0] INIT_VALUE    = {WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [WIDTH/8-1:0]    be,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      d,
   output logic [WIDTH-1:0]      q,
   output logic                  q_valid,
   output logic                  busy
);

   localparam int                    NB        = lanes(WIDTH);
   localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   RANGE_LIM = (ADDR_WIDTH + 1)'(DEPTH);

   generate
      if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
         $error("ram_be_pipe: READ_LATENCY must be 1 or 2");
      end
      if ((WIDTH % BYTE_W) != 0) begin : g_bad_width
         $error("ram_be_pipe: WIDTH must be a multiple of 8");
      end
   endgenerate

   // Replace the enabled byte lanes of old_w with those of new_w.
   function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_w,
                                                    input logic [WIDTH-1:0] new_w,
                                                    input logic [NB-1:0]    en);
      logic [WIDTH-1:0] res;
      res = old_w;
      for (int i = 0; i < NB; i++) begin
         if (en[i]) begin
            res[BYTE_W*i +: BYTE_W] = new_w[BYTE_W*i +: BYTE_W];
         end else begin
            res[BYTE_W*i +: BYTE_W] = old_w[BYTE_W*i +: BYTE_W];
         end
      end
      return res;
   endfunction

   logic [WIDTH-1:0]      mem_r [0:DEPTH-1];
   ram_state_t            state_r, state_s;
   logic [ADDR_WIDTH-1:0] cnt_r, cnt_s;
   logic                  busy_r;
   logic                  clr_wr_s, ready_s, in_range_s, wr_s, rd_s;
   logic [WIDTH-1:0]      old_s, merged_s, rd_data_s;
   logic                  v1_r;
   logic [WIDTH-1:0]      q1_r;

   // Clear FSM state, sweep counter and busy flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         cnt_r   <= {ADDR_WIDTH{1'b0}};
         busy_r  <= (CLEAR_ON_RESET != 0);
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         busy_r  <= (state_s == ST_CLEAR);
      end
   end

   // Next state: one word cleared per cycle, READY after the last address.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      clr_wr_s = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            clr_wr_s = 1'b1;
            if (cnt_r == LAST_ADDR) begin
               state_s = ST_READY;
               cnt_s   = {ADDR_WIDTH{1'b0}};
            end else begin
               state_s = ST_CLEAR;
               cnt_s   = cnt_r + ONE_ADDR;
            end
         end
         ST_READY: begin
            state_s = ST_READY;
         end
         default: begin
            state_s = ST_CLEAR;
            cnt_s   = {ADDR_WIDTH{1'b0}};
         end
      endcase
   end

   assign ready_s    = (state_r == ST_READY);
   assign in_range_s = ({1'b0, addr} < RANGE_LIM);
   assign wr_s       = ready_s & load & in_range_s;
   assign rd_s       = ready_s & rd_en;
   assign old_s      = mem_r[addr[IDX_W-1:0]];
   assign merged_s   = merge_lanes(old_s, d, be);

   // Read data: zero out of range, otherwise old word or write-merged word.
   always_comb begin
      rd_data_s = {WIDTH{1'b0}};
      if (!in_range_s) begin
         rd_data_s = {WIDTH{1'b0}};
      end else if ((WRITE_FIRST != 0) && load) begin
         rd_data_s = merged_s;
      end else begin
         rd_data_s = old_s;
      end
   end

   // Storage: sweep writes and lane-merged user writes; reset never touches contents.
   always_ff @(posedge clk) begin
      if (!reset && clr_wr_s) begin
         mem_r[cnt_r[IDX_W-1:0]] <= INIT_VALUE;
      end else if (!reset && wr_s) begin
         mem_r[addr[IDX_W-1:0]] <= merged_s;
      end
   end

   // First read stage: data only captured on an accepted read so q holds otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         v1_r <= 1'b0;
         q1_r <= {WIDTH{1'b0}};
      end else begin
         v1_r <= rd_s;
         if (rd_s) begin
            q1_r <= rd_data_s;
         end
      end
   end

   ram_rd_pipe #(
      .WIDTH  (WIDTH),
      .STAGES (READ_LATENCY - 1)
   ) u_rd_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (v1_r),
      .in_data   (q1_r),
      .out_valid (q_valid),
      .out_data  (q)
   );

   assign busy = busy_r;

endmodule
